// File: rtl/softmax_row_sched.sv
// softmax_row_sched
// Runs one multi-row softmax job at a time. Rows are read from an input row
// buffer, staged in a 2-entry FIFO, handed to the N-lane FP16 softmax block
// with valid/ready, and the normalized rows are written to an output row
// buffer. At most MAX_INFLIGHT rows are accepted by softmax and not yet
// written back. An abort stops new reads and drains rows already committed.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   softmax_rst_n_o     active-low reset for the softmax block (~rst_i)
//   start_i             job request, sampled in IDLE only
//   src_base_i          first source row address
//   dst_base_i          first destination row address
//   num_rows_i          rows in job (0..2^ADDR_W)
//   abort_i             level; stop issuing rows, drain in-flight rows
//   busy_o              job active
//   done_o              one-cycle pulse at job end
//   aborted_o           valid with done_o; job ended by abort
//   err_unexp_o         sticky; softmax result seen while idle
//   rd_en_o/rd_addr_o   input buffer read port, data back one cycle later
//   rd_data_i           input buffer read data
//   x_in_o/x_in_valid_o row to softmax; softmax_ready_i accepts it
//   softmax_i           result row; softmax_valid_i qualifies it
//   next_ready_o        ready towards softmax result side
//   wr_en_o/wr_addr_o/wr_data_o  output buffer write port
//   wr_ready_i          output buffer can accept a write
module softmax_row_sched #(
  parameter int N            = 64,
  parameter int ADDR_W       = 10,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                softmax_rst_n_o,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   src_base_i,
  input  logic [ADDR_W-1:0]   dst_base_i,
  input  logic [ADDR_W:0]     num_rows_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic                err_unexp_o,
  output logic                rd_en_o,
  output logic [ADDR_W-1:0]   rd_addr_o,
  input  logic [N*16-1:0]     rd_data_i,
  output logic [N*16-1:0]     x_in_o,
  output logic                x_in_valid_o,
  input  logic                softmax_ready_i,
  input  logic [N*16-1:0]     softmax_i,
  input  logic                softmax_valid_i,
  output logic                next_ready_o,
  output logic                wr_en_o,
  output logic [ADDR_W-1:0]   wr_addr_o,
  output logic [N*16-1:0]     wr_data_o,
  input  logic                wr_ready_i
);

  localparam int W  = N * 16;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW:0] STAGE_CAP    = (CW+1)'(2);
  localparam logic [CW:0] INFLIGHT_CAP = (CW+1)'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q;
  logic              busy_q, done_q, aborted_q, err_q;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [CW-1:0]     num_rows_q;
  logic [CW-1:0]     issued_q, accepted_q, written_q;
  logic [CW-1:0]     issued_d, accepted_d, written_d;
  logic              rd_pending_q;
  logic [W-1:0]      fifo_mem_q [2];
  logic              fifo_rd_ptr_q, fifo_wr_ptr_q;
  logic [1:0]        fifo_count_q, fifo_count_d;

  logic              rd_fire, x_fire, wr_fire;
  logic [CW:0]       staged, occupancy;

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path (defaults
    // first), otherwise synthesis would infer a latch.
    staged    = {{(CW-1){1'b0}}, fifo_count_q} + {{CW{1'b0}}, rd_pending_q};
    // Rows committed to this job but not yet written: in softmax, staged,
    // or with a read still in flight.
    occupancy = {1'b0, accepted_q - written_q} + staged;
    rd_fire   = 1'b0;
    if (state_q == RUN && !abort_i && issued_q < num_rows_q &&
        staged < STAGE_CAP && occupancy < INFLIGHT_CAP) begin
      rd_fire = 1'b1;
    end
    x_fire       = x_in_valid_o && softmax_ready_i;
    wr_fire      = softmax_valid_i && next_ready_o;
    issued_d     = issued_q   + {{(CW-1){1'b0}}, rd_fire};
    accepted_d   = accepted_q + {{(CW-1){1'b0}}, x_fire};
    written_d    = written_q  + {{(CW-1){1'b0}}, wr_fire};
    fifo_count_d = fifo_count_q + {1'b0, rd_pending_q} - {1'b0, x_fire};
  end

  assign softmax_rst_n_o = ~rst_i;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign aborted_o       = aborted_q;
  assign err_unexp_o     = err_q;
  assign rd_en_o         = rd_fire;
  assign rd_addr_o       = src_base_q + issued_q[ADDR_W-1:0];
  assign x_in_valid_o    = (fifo_count_q != 2'd0);
  assign x_in_o          = fifo_mem_q[fifo_rd_ptr_q];
  assign next_ready_o    = busy_q && wr_ready_i;
  assign wr_en_o         = wr_fire;
  assign wr_addr_o       = dst_base_q + written_q[ADDR_W-1:0];
  assign wr_data_o       = softmax_i;

  // NOTE: the staging storage is deliberately left out of reset; the count
  // and pointers are reset, so stale contents are never presented as valid.
  always_ff @(posedge clk_i) begin
    if (rd_pending_q) fifo_mem_q[fifo_wr_ptr_q] <= rd_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      err_q         <= 1'b0;
      src_base_q    <= '0;
      dst_base_q    <= '0;
      num_rows_q    <= '0;
      issued_q      <= '0;
      accepted_q    <= '0;
      written_q     <= '0;
      rd_pending_q  <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_count_q  <= 2'd0;
    end else begin
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      rd_pending_q <= rd_fire;
      issued_q     <= issued_d;
      accepted_q   <= accepted_d;
      written_q    <= written_d;
      fifo_count_q <= fifo_count_d;
      if (rd_pending_q) fifo_wr_ptr_q <= ~fifo_wr_ptr_q;
      if (x_fire)       fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      // A result while idle has no destination: flag it and drop it.
      if (softmax_valid_i && !busy_q) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_rows_i != '0) begin
              src_base_q <= src_base_i;
              dst_base_q <= dst_base_i;
              num_rows_q <= num_rows_i;
              issued_q   <= '0;
              accepted_q <= '0;
              written_q  <= '0;
              busy_q     <= 1'b1;
              state_q    <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (wr_fire && written_d == num_rows_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (abort_i && issued_q < num_rows_q) begin
            // Once every row is issued an abort has nothing left to cancel.
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count_q == 2'd0 && !rd_pending_q && written_q == accepted_q) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row_sched.sv
module tb_softmax_row_sched;
  localparam int N      = 64;
  localparam int ADDR_W = 10;
  localparam int MAXI   = 8;
  localparam int W      = N * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i, start_i, abort_i;
  logic [ADDR_W-1:0] src_base_i, dst_base_i;
  logic [ADDR_W:0]   num_rows_i;
  logic              softmax_rst_n_o, busy_o, done_o, aborted_o, err_unexp_o;
  logic              rd_en_o, x_in_valid_o, next_ready_o, wr_en_o;
  logic [ADDR_W-1:0] rd_addr_o, wr_addr_o;
  logic [W-1:0]      rd_data_i, x_in_o, softmax_i, wr_data_o;
  logic              softmax_ready_i, softmax_valid_i, wr_ready_i;

  softmax_row_sched #(.N(N), .ADDR_W(ADDR_W), .MAX_INFLIGHT(MAXI)) dut (
    .clk_i(clk), .rst_i(rst_i), .softmax_rst_n_o(softmax_rst_n_o),
    .start_i(start_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .num_rows_i(num_rows_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o), .err_unexp_o(err_unexp_o), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .x_in_o(x_in_o),
    .x_in_valid_o(x_in_valid_o), .softmax_ready_i(softmax_ready_i),
    .softmax_i(softmax_i), .softmax_valid_i(softmax_valid_i),
    .next_ready_o(next_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i)
  );

  // Environment: input buffer contents and a fake softmax with random latency.
  typedef struct { logic [W-1:0] data; int rdy; } sm_t;
  sm_t         sm_q[$];
  logic [31:0] seed_mem [1<<ADDR_W];
  logic [ADDR_W-1:0] pend_addr;

  // Job-level model: counts of reads, accepts and writes as seen at the ports.
  bit                m_busy, m_aborting, m_pend, m_done, m_ab, m_err;
  logic [ADDR_W-1:0] m_src, m_dst;
  int                m_num, m_iss, m_land, m_acc, m_wr;

  logic [ADDR_W-1:0] rd_log[$], wr_log[$];
  int  done_cnt, abort_cnt, last_wr_cyc, done_cyc, max_infl, cyc;
  bit  stall_prev, inj_valid;
  logic [W-1:0] x_prev;
  int  sr_mode, wr_mode, wr_low_until;
  int  n_checks, n_fail;

  function automatic logic [W-1:0] pat(input logic [31:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = s ^ (32'(i) * 32'h9E3779B9);
    return r;
  endfunction

  // What the fake softmax produces for a row: rotate one lane and scramble.
  function automatic logic [W-1:0] sm_fn(input logic [W-1:0] x);
    return {x[W-17:0], x[W-1:W-16]} ^ {(W/16){16'h5A5A}};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    int wi;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      wi = 0;
      for (int i = W/32 - 1; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) wi = i;
      $display("FAIL %s @cycle %0d: got %0h expected %0h (word %0d)",
               name, cyc, act[wi*32 +: 32], exp[wi*32 +: 32], wi);
    end
  endtask

  task automatic drive_env();
    case (sr_mode)
      0:       softmax_ready_i = 1'b1;
      1:       softmax_ready_i = (cyc % 3 == 0);
      default: softmax_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (cyc < wr_low_until) wr_ready_i = 1'b0;
    else wr_ready_i = (wr_mode == 0) ? 1'b1 : ($urandom % 4 != 0);
    if (sm_q.size() > 0 && cyc >= sm_q[0].rdy) begin
      softmax_valid_i = 1'b1;
      softmax_i       = sm_q[0].data;
    end else begin
      softmax_valid_i = inj_valid;
      softmax_i       = {(W/32){$urandom}};
    end
    rd_data_i = m_pend ? pat(seed_mem[pend_addr]) : {(W/32){32'hDEADBEEF}};
  endtask

  task automatic sample_check();
    bit exp_rd, acc_h, wr_h, busy0, nd, na;
    int iss0, acc0, wr0;
    logic [ADDR_W-1:0] a;
    exp_rd = m_busy && !m_aborting && !abort_i && m_iss < m_num &&
             (m_iss - m_acc) < 2 && (m_iss - m_wr) < MAXI;
    check("busy", busy_o, m_busy);
    check("done", done_o, m_done);
    check("aborted", aborted_o, m_ab);
    check("err_unexp", err_unexp_o, m_err);
    check("rd_en", rd_en_o, exp_rd);
    check("x_in_valid", x_in_valid_o, m_land > m_acc);
    check("next_ready", next_ready_o, m_busy && wr_ready_i);
    check("wr_en", wr_en_o, softmax_valid_i && m_busy && wr_ready_i);
    check("softmax_rst_n", softmax_rst_n_o, !rst_i);
    if (stall_prev) check("x_in_held", x_in_o, x_prev);
    acc_h = x_in_valid_o && softmax_ready_i;
    wr_h  = wr_en_o;
    if (rd_en_o) begin
      a = m_src + ADDR_W'(m_iss);
      check("rd_addr", rd_addr_o, a);
    end
    if (acc_h) begin
      a = m_src + ADDR_W'(m_acc);
      check("x_in_row", x_in_o, pat(seed_mem[a]));
    end
    if (wr_h) begin
      a = m_dst + ADDR_W'(m_wr);
      check("wr_addr", wr_addr_o, a);
      a = m_src + ADDR_W'(m_wr);
      check("wr_data", wr_data_o, sm_fn(pat(seed_mem[a])));
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      if (aborted_o) abort_cnt++;
    end
    stall_prev = x_in_valid_o && !softmax_ready_i;
    x_prev     = x_in_o;

    if (rst_i) begin
      m_busy = 0; m_aborting = 0; m_pend = 0; m_done = 0; m_ab = 0; m_err = 0;
      m_iss = 0; m_land = 0; m_acc = 0; m_wr = 0;
      sm_q.delete();
      stall_prev = 0;
      return;
    end

    busy0 = m_busy; iss0 = m_iss; acc0 = m_acc; wr0 = m_wr;
    nd = 0; na = 0;
    if (!busy0) begin
      if (start_i) begin
        if (num_rows_i != 0) begin
          m_busy = 1; m_aborting = 0;
          m_src = src_base_i; m_dst = dst_base_i; m_num = int'(num_rows_i);
          m_iss = 0; m_land = 0; m_acc = 0; m_wr = 0;
        end else nd = 1;
      end
    end else begin
      if (rd_en_o) begin
        rd_log.push_back(rd_addr_o);
        m_iss++;
      end
      if (acc_h) begin
        sm_q.push_back('{data: sm_fn(x_in_o), rdy: cyc + 1 + int'($urandom_range(0, 3))});
        m_acc++;
      end
      if (wr_h) begin
        wr_log.push_back(wr_addr_o);
        m_wr++;
        last_wr_cyc = cyc;
        if (sm_q.size() > 0) void'(sm_q.pop_front());
      end
      if (m_acc - m_wr > max_infl) max_infl = m_acc - m_wr;
      if (wr_h && m_wr == m_num) begin
        nd = 1; m_busy = 0;
      end else if (m_aborting) begin
        if (iss0 == acc0 && acc0 == wr0) begin
          nd = 1; na = 1; m_busy = 0;
        end
      end else if (abort_i && iss0 < m_num) begin
        m_aborting = 1;
      end
    end
    if (softmax_valid_i && !busy0) m_err = 1;
    if (m_pend) m_land++;
    m_pend    = rd_en_o && busy0;
    pend_addr = rd_addr_o;
    m_done = nd; m_ab = na;
  endtask

  task automatic step();
    #1;
    sample_check();
    cyc++;
    @(negedge clk);
    drive_env();
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d, input int n);
    src_base_i = s; dst_base_i = d; num_rows_i = (ADDR_W+1)'(n);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = done_cnt; k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    check("done_within_budget", done_cnt != d0, 1'b1);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k;
    k = 0;
    while (m_acc < target && k < budget) begin
      step();
      k++;
    end
    check("accept_within_budget", m_acc >= target, 1'b1);
  endtask

  task automatic new_test(input int srm, input int wrm);
    sr_mode = srm; wr_mode = wrm;
    rd_log.delete(); wr_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] wrap_exp [5];
    int d0, a0, nrd, n;
    logic [ADDR_W-1:0] s, d;
    for (int i = 0; i < (1<<ADDR_W); i++) seed_mem[i] = $urandom;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; inj_valid = 1'b0;
    src_base_i = '0; dst_base_i = '0; num_rows_i = '0;
    sr_mode = 0; wr_mode = 0; wr_low_until = 0; cyc = 0;
    @(negedge clk);
    drive_env();
    step(); step();
    rst_i = 1'b0;
    step();

    // Single row.
    new_test(0, 0);
    start_job(10'h010, 10'h200, 1);
    wait_done(50);
    check("single_rd_count", rd_log.size(), 1);
    check("single_rd_addr", rd_log[0], 10'h010);
    check("single_wr_count", wr_log.size(), 1);
    check("single_wr_addr", wr_log[0], 10'h200);
    check("single_done_latency", done_cyc - last_wr_cyc, 1);
    step();

    // Back-to-back with address wrap.
    new_test(0, 0);
    wrap_exp = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002};
    d0 = done_cnt;
    start_job(10'h3FE, 10'h123, 5);
    wait_done(80);
    for (int i = 0; i < 4; i++) step();
    check("wrap_rd_count", rd_log.size(), 5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++) check("wrap_rd_seq", rd_log[i], wrap_exp[i]);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) check("wrap_wr_seq", wr_log[i] - 10'h123, ADDR_W'(i));
    check("wrap_done_once", done_cnt - d0, 1);

    // Backpressure: 1-in-3 accept, output buffer blocked for 40 cycles.
    new_test(1, 0);
    max_infl = 0;
    wr_low_until = cyc + 41;
    start_job(10'h080, 10'h300, 20);
    wait_done(400);
    check("bp_max_inflight", max_infl, MAXI);
    check("bp_wr_count", wr_log.size(), 20);

    // Abort after the 6th accept.
    new_test(2, 1);
    a0 = abort_cnt;
    start_job(10'h040, 10'h0C0, 16);
    wait_acc(6, 300);
    abort_i = 1'b1;
    nrd = rd_log.size();
    wait_done(300);
    abort_i = 1'b0;
    check("abort_no_new_reads", rd_log.size(), nrd);
    check("abort_pulsed", abort_cnt - a0, 1);
    check("abort_written_eq_acc", m_wr, m_acc);
    check("abort_acc_bounds", m_acc >= 6 && m_acc <= 9, 1'b1);
    step();

    // Abort after every row is already issued: normal completion.
    new_test(0, 0);
    a0 = abort_cnt;
    wr_low_until = cyc + 12;
    start_job(10'h200, 10'h210, 3);
    for (int k = 0; k < 20 && m_iss < 3; k++) step();
    abort_i = 1'b1;
    wait_done(100);
    abort_i = 1'b0;
    check("late_abort_not_aborted", abort_cnt, a0);
    check("late_abort_wr_count", wr_log.size(), 3);

    // Zero-row job.
    new_test(0, 0);
    d0 = done_cnt;
    start_job(10'h055, 10'h066, 0);
    step(); step();
    check("zero_done_once", done_cnt - d0, 1);
    check("zero_no_reads", rd_log.size(), 0);

    // Start while busy is ignored.
    new_test(0, 0);
    start_job(10'h100, 10'h300, 6);
    step();
    src_base_i = 10'h000; dst_base_i = 10'h000; num_rows_i = 11'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(100);
    check("busy_start_wr_count", wr_log.size(), 6);
    check("busy_start_first_rd", rd_log[0], 10'h100);
    check("busy_start_first_wr", wr_log[0], 10'h300);

    // Randomized jobs.
    for (int j = 0; j < 5; j++) begin
      new_test(2, 1);
      s = ADDR_W'($urandom); d = ADDR_W'($urandom); n = int'($urandom_range(1, 24));
      start_job(s, d, n);
      wait_done(600);
      check("rand_wr_count", wr_log.size(), n);
    end

    // Result while idle sets the sticky error.
    new_test(0, 0);
    inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
    step(); step(); step();
    check("err_sticky", err_unexp_o, 1'b1);

    // Reset in the middle of a 12-row job.
    new_test(2, 1);
    start_job(10'h020, 10'h3F8, 12);
    wait_acc(7, 300);
    d0 = done_cnt;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_unexp_o, 1'b0);
    check("rst_rd_en", rd_en_o, 1'b0);
    check("rst_x_valid", x_in_valid_o, 1'b0);
    check("rst_wr_en", wr_en_o, 1'b0);
    for (int k = 0; k < 10; k++) step();
    check("rst_no_done", done_cnt, d0);
    new_test(0, 0);
    start_job(10'h3FF, 10'h001, 3);
    wait_done(100);
    check("post_rst_wr_count", wr_log.size(), 3);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
